// File: rtl/misa_csr_ctrl.sv
// misa_csr_ctrl: live misa CSR with WARL-legalized writes over a valid/ready request/response path.
// Optional feature macro: MISA_WRITE_LOCK_EN (adds lock_i; locked writes commit nothing and report an error).
`default_nettype none

module misa_csr_ctrl #(
  parameter logic [1:0]  CSR_MISA_MXL = 2'd1,
  parameter bit          RV32M        = 1'b1,
  parameter bit          RV32E        = 1'b0,
  parameter logic [31:0] WARL_MASK    = 32'h0000_1004
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_wdata_i,
`ifdef MISA_WRITE_LOCK_EN
  input  logic        lock_i,
`endif
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] misa_o,
  output logic        ext_c_en_o,
  output logic        ext_e_o,
  output logic        ext_i_o,
  output logic        ext_m_en_o,
  output logic [1:0]  mxl_o
);

  localparam logic [31:0] MISA_RESET = (32'(1'b1)         << 2)
                                     | (32'(RV32E)        << 4)
                                     | (32'(!RV32E)       << 8)
                                     | (32'(RV32M)        << 12)
                                     | (32'(1'b1)         << 20)
                                     | (32'(CSR_MISA_MXL) << 30);

  // An extension absent from the reset configuration can never be switched on.
  localparam logic [31:0] EFF_MASK = WARL_MASK & MISA_RESET;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEGAL = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] misa_q, misa_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        lock_q, lock_d;

  logic        lock_in;
`ifdef MISA_WRITE_LOCK_EN
  assign lock_in = lock_i;
`else
  assign lock_in = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      misa_q  <= MISA_RESET;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      misa_q  <= misa_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    misa_d      = misa_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    lock_d      = lock_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i && req_ready_o) begin
          if (req_we_i) begin
            // misa cannot change before LEGAL, so misa_q still holds the pre-write value there.
            wdata_d = req_wdata_i;
            lock_d  = lock_in;
            state_d = ST_LEGAL;
          end else begin
            rdata_d = misa_q;
            err_d   = 1'b0;
            state_d = ST_RESP;
          end
        end
      end

      ST_LEGAL: begin
        rdata_d = misa_q;
        if (lock_q) begin
          err_d = 1'b1;
        end else begin
          misa_d = (misa_q & ~EFF_MASK) | (wdata_q & EFF_MASK);
          err_d  = |((wdata_q ^ misa_q) & ~EFF_MASK);
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign misa_o      = misa_q;
  assign ext_c_en_o  = misa_q[2];
  assign ext_e_o     = misa_q[4];
  assign ext_i_o     = misa_q[8];
  assign ext_m_en_o  = misa_q[12];
  assign mxl_o       = misa_q[31:30];

endmodule

`default_nettype wire
